// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter slice.
// Register-file geometry and RV32I load funct3 encodings.
package wb_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

endpackage

// File: rtl/wb_mc_fifo.sv
// Small sync FIFO holding multi-cycle results awaiting the write port.
// Exposes a per-slot destination match for hazard queries from decode.
module wb_mc_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [REG_AW-1:0] push_rd,
    input  logic [XLEN-1:0]   push_data,
    output logic [REG_AW-1:0] head_rd,
    output logic [XLEN-1:0]   head_data,
    output logic              full,
    output logic              empty,
    input  logic [REG_AW-1:0] q_addr,
    output logic [DEPTH-1:0]  match
);

    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic [AW-1:0]     rel;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_rd   = rd_mem[rptr];
    assign head_data = data_mem[rptr];

    // Entry storage; payload needs no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr]   <= push_rd;
            data_mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A slot matches only if it lies within the occupied window.
    always_comb begin
        rel   = '0;
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel      = AW'(i) - rptr;
            match[i] = ({1'b0, rel} < count) && (rd_mem[i] == q_addr);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline and multi-cycle results onto
// the single regfile write port, formatting loads on the way.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int MC_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [REG_AW-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_data,
    input  logic              pipe_ld,
    input  logic [2:0]        pipe_funct3,
    input  logic [1:0]        pipe_byte_off,
    output logic              pipe_stall,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [REG_AW-1:0] mc_rd,
    input  logic [XLEN-1:0]   mc_data,
    input  logic [REG_AW-1:0] q_addr,
    output logic              q_pending,
    output logic              w_regs_en,
    output logic [REG_AW-1:0] w_regs_addr,
    output logic [XLEN-1:0]   w_regs_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [REG_AW-1:0]   head_rd;
    logic [XLEN-1:0]     head_data;
    logic                full;
    logic                empty;
    logic [MC_DEPTH-1:0] match;
    logic [SW-1:0]       starve_cnt;
    logic                sel_pipe;
    logic                pop;
    logic                push;

    function automatic logic [XLEN-1:0] fmt_load(
        input logic [XLEN-1:0] d,
        input logic [2:0]      f3,
        input logic [1:0]      off
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        unique case (1'b1)
            f3 == LB:  r = {{(XLEN-8){b[7]}}, b};
            f3 == LBU: r = {{(XLEN-8){1'b0}}, b};
            f3 == LH:  r = {{(XLEN-16){h[15]}}, h};
            f3 == LHU: r = {{(XLEN-16){1'b0}}, h};
            default:   r = d;
        endcase
        return r;
    endfunction

    wb_mc_fifo #(
        .DEPTH (MC_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_rd   (mc_rd),
        .push_data (mc_data),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .q_addr    (q_addr),
        .match     (match)
    );

    // Arbitration: pipeline first unless the FIFO head has starved.
    always_comb begin
        pipe_stall = (starve_cnt == SW'(STARVE_LIMIT)) && !empty;
        sel_pipe   = pipe_valid && !pipe_stall;
        pop        = !sel_pipe && !empty;
        mc_ready   = !rst && !full;
        push       = mc_valid && mc_ready;
        q_pending  = (q_addr != '0) && (|match);
    end

    // Count cycles the head waits behind the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if (sel_pipe && !empty) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered write port; rd 0 is selected but never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_regs_en   <= 1'b0;
            w_regs_addr <= '0;
            w_regs_data <= '0;
        end else if (sel_pipe) begin
            w_regs_en   <= (pipe_rd != '0);
            w_regs_addr <= pipe_rd;
            w_regs_data <= pipe_ld ?
                fmt_load(pipe_data, pipe_funct3, pipe_byte_off) :
                pipe_data;
        end else if (pop) begin
            w_regs_en   <= (head_rd != '0);
            w_regs_addr <= head_rd;
            w_regs_data <= head_data;
        end else begin
            w_regs_en   <= 1'b0;
            w_regs_addr <= '0;
            w_regs_data <= '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: load table, directed
// multi-cycle sequences and random traffic against a queue model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int MC_DEPTH     = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_ld;
    logic [2:0]  pipe_funct3;
    logic [1:0]  pipe_byte_off;
    logic        pipe_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic [4:0]  q_addr;
    logic        q_pending;
    logic        w_regs_en;
    logic [4:0]  w_regs_addr;
    logic [31:0] w_regs_data;

    always #5 clk = ~clk;

    wb_arbiter #(
        .MC_DEPTH     (MC_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_valid    (pipe_valid),
        .pipe_rd       (pipe_rd),
        .pipe_data     (pipe_data),
        .pipe_ld       (pipe_ld),
        .pipe_funct3   (pipe_funct3),
        .pipe_byte_off (pipe_byte_off),
        .pipe_stall    (pipe_stall),
        .mc_valid      (mc_valid),
        .mc_ready      (mc_ready),
        .mc_rd         (mc_rd),
        .mc_data       (mc_data),
        .q_addr        (q_addr),
        .q_pending     (q_pending),
        .w_regs_en     (w_regs_en),
        .w_regs_addr   (w_regs_addr),
        .w_regs_data   (w_regs_data)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    typedef struct packed {
        logic        ld;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] d;
        logic [31:0] e;
    } lv_t;

    ent_t        mq[$];
    int          mst;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          n_vec = 0;
    int          n_err = 0;
    logic        s_stall;
    logic        s_ready;
    logic        s_qp;
    lv_t         tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_fmt(input logic ld,
        input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> {off, 3'b000}) & 32'hFF;
        h = (d >> {off[1], 4'b0000}) & 32'hFFFF;
        if (!ld) return d;
        case (f3)
            3'd0:    return b[7] ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic logic m_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check combinational outputs, advance model, check writes.
    task automatic step();
        logic e_stall;
        logic e_ready;
        logic e_qp;
        ent_t h;
        @(negedge clk);
        e_stall = (mst == STARVE_LIMIT) && (mq.size() > 0);
        e_ready = !rst && (mq.size() < MC_DEPTH);
        e_qp    = m_pend(q_addr);
        s_stall = pipe_stall;
        s_ready = mc_ready;
        s_qp    = q_pending;
        chk("pipe_stall", {31'b0, pipe_stall}, {31'b0, e_stall});
        chk("mc_ready", {31'b0, mc_ready}, {31'b0, e_ready});
        chk("q_pending", {31'b0, q_pending}, {31'b0, e_qp});
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mst    = 0;
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (pipe_valid && !e_stall) begin
                m_en   = (pipe_rd != 5'd0);
                m_addr = pipe_rd;
                m_data = m_fmt(pipe_ld, pipe_funct3, pipe_byte_off,
                               pipe_data);
                if (mq.size() > 0) mst++;
            end else if (mq.size() > 0) begin
                h      = mq.pop_front();
                m_en   = (h.rd != 5'd0);
                m_addr = h.rd;
                m_data = h.d;
                mst    = 0;
            end else begin
                m_en = 1'b0;
            end
            if (mc_valid && e_ready) mq.push_back({mc_rd, mc_data});
        end
        #1;
        chk("w_regs_en", {31'b0, w_regs_en}, {31'b0, m_en});
        if (m_en) begin
            chk("w_regs_addr", {27'b0, w_regs_addr}, {27'b0, m_addr});
            chk("w_regs_data", w_regs_data, m_data);
        end
    endtask

    task automatic idle();
        rst           = 1'b0;
        pipe_valid    = 1'b0;
        pipe_rd       = '0;
        pipe_data     = '0;
        pipe_ld       = 1'b0;
        pipe_funct3   = '0;
        pipe_byte_off = '0;
        mc_valid      = 1'b0;
        mc_rd         = '0;
        mc_data       = '0;
        q_addr        = '0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, LB,   2'd3, 32'h80FF0000, 32'hFFFFFF80};
        tbl[1]  = '{1'b1, LBU,  2'd3, 32'h80FF0000, 32'h00000080};
        tbl[2]  = '{1'b1, LH,   2'd2, 32'h80FF0000, 32'hFFFF80FF};
        tbl[3]  = '{1'b1, LHU,  2'd2, 32'h80FF0000, 32'h000080FF};
        tbl[4]  = '{1'b1, LB,   2'd2, 32'h80FF0000, 32'hFFFFFFFF};
        tbl[5]  = '{1'b1, LBU,  2'd0, 32'h80FF0012, 32'h00000012};
        tbl[6]  = '{1'b1, LH,   2'd1, 32'h12348765, 32'hFFFF8765};
        tbl[7]  = '{1'b1, LHU,  2'd3, 32'h12348765, 32'h00001234};
        tbl[8]  = '{1'b1, LW,   2'd1, 32'hCAFEBABE, 32'hCAFEBABE};
        tbl[9]  = '{1'b1, 3'd3, 2'd0, 32'h00000001, 32'h00000001};
        tbl[10] = '{1'b0, LB,   2'd3, 32'h80FF0000, 32'h80FF0000};
        tbl[11] = '{1'b1, LB,   2'd1, 32'h00007F00, 32'h0000007F};

        mst = 0; m_en = 0; m_addr = 0; m_data = 0;
        idle();
        rst = 1'b1;
        step();
        chk("reset_en", {31'b0, w_regs_en}, 32'd0);
        chk("reset_addr", {27'b0, w_regs_addr}, 32'd0);
        chk("reset_data", w_regs_data, 32'd0);
        rst = 1'b0;

        // Load formatting table
        for (int i = 0; i < 12; i++) begin
            pipe_valid    = 1'b1;
            pipe_rd       = 5'd3;
            pipe_ld       = tbl[i].ld;
            pipe_funct3   = tbl[i].f3;
            pipe_byte_off = tbl[i].off;
            pipe_data     = tbl[i].d;
            step();
            chk("ld_tbl_en", {31'b0, w_regs_en}, 32'd1);
            chk("ld_tbl_data", w_regs_data, tbl[i].e);
        end
        idle();

        // Multi-cycle result, no bypass, written one edge after accept
        mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'h1234;
        step();
        chk("t1_ready", {31'b0, s_ready}, 32'd1);
        chk("t1_nobypass", {31'b0, w_regs_en}, 32'd0);
        mc_valid = 1'b0;
        step();
        chk("t1_en", {31'b0, w_regs_en}, 32'd1);
        chk("t1_addr", {27'b0, w_regs_addr}, 32'd5);
        chk("t1_data", w_regs_data, 32'h00001234);

        // Starvation: fill while pipeline streams
        pipe_valid = 1'b1; pipe_rd = 5'd9;
        for (int c = 0; c < 5; c++) begin
            pipe_data = 32'hABCD0000 + c;
            mc_valid  = 1'b1;
            mc_rd     = 5'(10 + c);
            mc_data   = 32'h5000 + c;
            step();
            if (c >= 2) begin
                chk("t3_full", {31'b0, s_ready}, 32'd0);
                chk("t3_nostall", {31'b0, s_stall}, 32'd0);
            end
        end
        pipe_data = 32'hABCD0005;
        step();
        chk("t3_stall", {31'b0, s_stall}, 32'd1);
        chk("t3_head_addr", {27'b0, w_regs_addr}, 32'd10);
        chk("t3_head_data", w_regs_data, 32'h5000);
        mc_valid = 1'b0;
        step();
        chk("t3_held_addr", {27'b0, w_regs_addr}, 32'd9);
        chk("t3_held_data", w_regs_data, 32'hABCD0005);
        pipe_valid = 1'b0;
        step();
        chk("t3_drain", {27'b0, w_regs_addr}, 32'd11);
        step();

        // rd 0 pipeline result: selected, no write, FIFO holds
        mc_valid = 1'b1; mc_rd = 5'd6; mc_data = 32'h66;
        step();
        mc_valid = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
        q_addr = 5'd6;
        step();
        chk("t4_no_write", {31'b0, w_regs_en}, 32'd0);
        pipe_valid = 1'b0;
        step();
        chk("t4_still_q", {31'b0, s_qp}, 32'd1);
        chk("t4_late_addr", {27'b0, w_regs_addr}, 32'd6);

        // q_pending tracking
        q_addr = 5'd7;
        mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h77;
        pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
        step();
        mc_valid = 1'b0;
        step();
        chk("t5_pend", {31'b0, s_qp}, 32'd1);
        pipe_valid = 1'b0;
        step();
        step();
        chk("t5_clear", {31'b0, s_qp}, 32'd0);
        q_addr = 5'd0;
        mc_valid = 1'b1; mc_rd = 5'd0;
        step();
        mc_valid = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd2;
        step();
        chk("t5_zero", {31'b0, s_qp}, 32'd0);
        pipe_valid = 1'b0;
        step();

        // Reset with two buffered entries
        pipe_valid = 1'b1; pipe_rd = 5'd4;
        mc_valid = 1'b1; mc_rd = 5'd13; mc_data = 32'hD13;
        step();
        mc_rd = 5'd14; mc_data = 32'hD14;
        step();
        mc_valid = 1'b1;
        rst = 1'b1;
        step();
        chk("t6_ready_rst", {31'b0, s_ready}, 32'd0);
        chk("t6_en_rst", {31'b0, w_regs_en}, 32'd0);
        idle();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_no_stale", {31'b0, w_regs_en}, 32'd0);
        end

        // Random traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!s_stall) begin
                pipe_valid    = ($urandom_range(0, 3) != 0);
                pipe_rd       = 5'($urandom_range(0, 7));
                pipe_data     = $urandom;
                pipe_ld       = $urandom_range(0, 1) == 1;
                pipe_funct3   = 3'($urandom_range(0, 7));
                pipe_byte_off = 2'($urandom_range(0, 3));
            end
            mc_valid = ($urandom_range(0, 2) == 0);
            mc_rd    = 5'($urandom_range(0, 7));
            mc_data  = $urandom;
            q_addr   = 5'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Write-back stage directly upstream of the register file. Merges the in-order pipeline result (MEM/WB) and results from a multi-cycle unit (MUL/DIV) onto the regfile's single write port. Formats load data and buffers multi-cycle results in a small FIFO. Drives the registered w_regs_en / w_regs_addr / w_regs_data consumed by the regfile, whose same-cycle forwarding covers the write cycle.

Parameters:
MC_DEPTH, 2, multi-cycle result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive cycles the FIFO head may wait before the pipeline is stalled

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
pipe_valid  in  1  pipeline result present this cycle
pipe_rd  in  5  destination register
pipe_data  in  32  ALU result, or raw aligned memory word for loads
pipe_ld  in  1  result is a load; format per funct3/offset
pipe_funct3  in  3  RV32I load funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5)
pipe_byte_off  in  2  load address[1:0]
pipe_stall  out  1  upstream must hold pipe_* this cycle
mc_valid  in  1  multi-cycle result offered
mc_ready  out  1  FIFO can accept (valid&&ready = accept)
mc_rd  in  5  multi-cycle destination
mc_data  in  32  multi-cycle result
q_addr  in  5  decode query register
q_pending  out  1  some FIFO entry targets q_addr (q_addr != 0)
w_regs_en  out  1  regfile write enable
w_regs_addr  out  5  regfile write address
w_regs_data  out  32  regfile write data

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, starve counter cleared, w_regs_en/addr/data = 0. mc_ready = 0 while rst is high. Reset mid-operation discards all buffered results.
- Output register: w_regs_* loaded every edge from the selected source. w_regs_en = 0 when no source is selected or the selected rd == 0. Latency is 1 cycle: pipe_* sampled at edge E appears on w_regs_* after E.
- Selection per cycle:
  - pipe_valid && !pipe_stall → pipeline wins. FIFO holds. Starve counter increments if the FIFO is non-empty.
  - Else, FIFO non-empty → pop head and write it. Starve counter cleared.
  - Else → idle, w_regs_en = 0.
- pipe_valid with pipe_rd == 0 still counts as selected (no write, FIFO does not drain). This is deliberate and keeps the arbitration simple.
- Starvation: pipe_stall = (starve_cnt == STARVE_LIMIT) && FIFO non-empty, combinational. In a stall cycle the pipe input is ignored and the head pops. Upstream holds pipe_* and it is consumed in the next cycle.
- FIFO: mc_ready = (count < MC_DEPTH), from registered count. No enqueue when full, even if a pop occurs that cycle. Simultaneous push and pop when not full leaves count unchanged. Pointers wrap modulo MC_DEPTH. No bypass: an accepted entry reaches w_regs_* no earlier than 2 edges after acceptance.
- q_pending is combinational over all valid FIFO entries. Decode must stall on q_pending; WAW ordering between the pipe and the FIFO is decode's responsibility.
- Load formatting (pipe_ld = 1):
  - LB/LBU select byte pipe_byte_off; sign- or zero-extend to 32 bits.
  - LH/LHU select halfword pipe_byte_off[1]; pipe_byte_off[0] is ignored.
  - LW and other funct3 values pass the word unchanged.
  - pipe_ld = 0 passes pipe_data unchanged.

Decomposition:
- Shared package: load funct3 constants (LB, LH, LW, LBU, LHU); XLEN = 32; REG_AW = 5.
- One sub-module: wb_mc_fifo (sync FIFO with count, full/empty, and an entry-address match vector for q_pending).
- Load formatter stays inline as a function.

Test Plan:
1. mc_valid with rd=5, data=0x1234, pipe idle → mc_ready=1. Two edges later w_regs_en=1, addr=5, data=0x00001234.
2. pipe_ld=1, funct3=LB, off=3, data=0x80FF_0000 → w_regs_data=0xFFFFFF80 one cycle later. Same input with LBU → 0x00000080. LH with off=2 → 0xFFFF80FF.
3. Fill FIFO (2 entries) while pipe_valid=1 continuously → mc_ready=0 after the 2nd accept. After 4 starved cycles pipe_stall=1 for one cycle and the head writes. Held pipe data is written the next cycle.
4. pipe_valid=1 with pipe_rd=0 and data=0xDEAD → w_regs_en=0. FIFO does not drain that cycle.
5. q_addr=7 with a buffered entry rd=7 → q_pending=1. After that entry drains → 0. q_addr=0 → always 0.
6. Assert rst for one edge with 2 entries buffered → FIFO empty, w_regs_en=0, mc_ready=0 during rst, no stale writes afterwards.
